// File: rtl/uart_cmd_ctrl_if.sv
// Bundles the UART-side byte strobe and the register-bank write port of uart_cmd_ctrl.
// The slave modport is the controller's view; the master modport drives bytes in and observes writes.
interface uart_cmd_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              rx_dv;
    logic [7:0]        rx_byte;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              frame_err;
    logic [7:0]        err_cnt;
    logic              busy;

    modport master (
        output rx_dv, rx_byte,
        input  wr_en, wr_addr, wr_data, frame_err, err_cnt, busy
    );

    modport slave (
        input  rx_dv, rx_byte,
        output wr_en, wr_addr, wr_data, frame_err, err_cnt, busy
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Turns UART bytes into validated register writes (SYNC, ADDR, DATA[, CHK] frames).
// Define UART_CMD_CHKSUM_EN to add the trailing XOR checksum byte to every frame.
module uart_cmd_ctrl #(
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int          ADDR_W       = 4,
    parameter logic [15:0] TIMEOUT_CLKS = 16'd3000
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_cmd_ctrl_if.slave   bus
);

`ifdef UART_CMD_CHKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_CHK,
        ST_COMMIT
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_COMMIT
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [15:0]       tmo_q, tmo_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              frame_err_q, frame_err_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic              waiting;
    logic              reject;

    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        addr_d      = addr_q;
        data_d      = data_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        reject      = 1'b0;
        waiting     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.rx_dv && (bus.rx_byte == SYNC_BYTE)) begin
                    state_d = ST_ADDR;
                    tmo_d   = 16'd0;
                end
            end
            ST_ADDR: begin
                waiting = 1'b1;
                if (bus.rx_dv) begin
                    addr_d = bus.rx_byte[ADDR_W-1:0];
                    tmo_d  = 16'd0;
                    if ((bus.rx_byte >> ADDR_W) != 8'd0) begin
                        reject = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                waiting = 1'b1;
                if (bus.rx_dv) begin
                    data_d = bus.rx_byte;
                    tmo_d  = 16'd0;
`ifdef UART_CMD_CHKSUM_EN
                    state_d = ST_CHK;
`else
                    state_d = ST_COMMIT;
`endif
                end
            end
`ifdef UART_CMD_CHKSUM_EN
            // Accepted addresses have zero upper bits, so the short register zero-extends to the received byte.
            ST_CHK: begin
                waiting = 1'b1;
                if (bus.rx_dv) begin
                    tmo_d = 16'd0;
                    if (bus.rx_byte != (8'(addr_q) ^ data_q)) begin
                        reject = 1'b1;
                    end else begin
                        state_d = ST_COMMIT;
                    end
                end
            end
`endif
            ST_COMMIT: begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = data_q;
                tmo_d     = 16'd0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                tmo_d   = 16'd0;
            end
        endcase

        // A byte arriving on the expiry cycle wins; the timeout only fires on a silent cycle.
        if (waiting && !bus.rx_dv) begin
            if (tmo_q == TIMEOUT_CLKS) begin
                reject = 1'b1;
            end else begin
                tmo_d = tmo_q + 16'd1;
            end
        end

        if (reject) begin
            frame_err_d = 1'b1;
            state_d     = ST_IDLE;
            tmo_d       = 16'd0;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tmo_q       <= 16'd0;
            addr_q      <= '0;
            data_q      <= 8'd0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 8'd0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.frame_err = frame_err_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: table-driven frames, timeout/saturation/reset sequences and
// randomized frame streams, all compared every cycle against a byte-list reference model.
module tb_uart_cmd_ctrl;

    localparam logic [7:0] SYNC   = 8'hA5;
    localparam int         ADDR_W = 4;
    localparam int         TMO    = 3000;
`ifdef UART_CMD_CHKSUM_EN
    localparam int         NB     = 4;
`else
    localparam int         NB     = 3;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_cmd_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    uart_cmd_ctrl #(
        .SYNC_BYTE   (SYNC),
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CLKS(16'(TMO))
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Reference model: the frame is the list of bytes collected since SYNC.
    logic [7:0] fr[$];
    int         waited;
    bit         commit_pend;
    logic       m_wr_en, m_err, m_busy;
    logic [3:0] m_addr;
    logic [7:0] m_data, m_cnt;

    int         checks = 0;
    int         passes = 0;
    int         obs_wr, obs_err;
    logic [3:0] obs_addr;
    logic [7:0] obs_data;

    typedef struct packed {
        logic [2:0]  n;
        logic [31:0] bytes;
        logic [15:0] gap;
        logic        exp_wr;
        logic [3:0]  exp_addr;
        logic [7:0]  exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[5];

    function automatic void modelReset();
        fr.delete();
        waited      = 0;
        commit_pend = 0;
        m_wr_en     = 1'b0;
        m_err       = 1'b0;
        m_busy      = 1'b0;
        m_addr      = 4'd0;
        m_data      = 8'd0;
        m_cnt       = 8'd0;
    endfunction

    function automatic void modelReject();
        m_err = 1'b1;
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        fr.delete();
        m_busy = 1'b0;
    endfunction

    // One clock of the model: dv/b are the inputs sampled at the edge, results are post-edge outputs.
    function automatic void modelStep(input logic dv, input logic [7:0] b);
        logic [7:0] a;
        m_wr_en = 1'b0;
        m_err   = 1'b0;
        if (commit_pend) begin
            commit_pend = 0;
            a       = fr[1];
            m_wr_en = 1'b1;
            m_addr  = a[3:0];
            m_data  = fr[2];
            fr.delete();
            m_busy  = 1'b0;
        end else if (fr.size() == 0) begin
            if (dv && b == SYNC) begin
                fr.push_back(b);
                waited = 0;
                m_busy = 1'b1;
            end
        end else if (dv) begin
            fr.push_back(b);
            waited = 0;
            if (fr.size() == 2 && (b >> ADDR_W) != 8'd0) modelReject();
            else if (fr.size() == NB) begin
                if (NB == 4 && b != (fr[1] ^ fr[2])) modelReject();
                else commit_pend = 1;
            end
        end else if (waited == TMO) begin
            modelReject();
        end else begin
            waited++;
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic checkAll();
        checkOutput("wr_en",     32'(bus.wr_en),     32'(m_wr_en));
        checkOutput("wr_addr",   32'(bus.wr_addr),   32'(m_addr));
        checkOutput("wr_data",   32'(bus.wr_data),   32'(m_data));
        checkOutput("frame_err", 32'(bus.frame_err), 32'(m_err));
        checkOutput("err_cnt",   32'(bus.err_cnt),   32'(m_cnt));
        checkOutput("busy",      32'(bus.busy),      32'(m_busy));
    endtask

    task automatic tick(input logic dv, input logic [7:0] b);
        @(negedge clk);
        bus.rx_dv   = dv;
        bus.rx_byte = b;
        modelStep(dv, b);
        @(posedge clk);
        #1;
        if (bus.wr_en === 1'b1) begin
            obs_wr++;
            obs_addr = bus.wr_addr;
            obs_data = bus.wr_data;
        end
        if (bus.frame_err === 1'b1) obs_err++;
        checkAll();
    endtask

    // gap = clocks from the previous strobe to this one (1 = back to back).
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        repeat (gap - 1) tick(1'b0, 8'($urandom));
        tick(1'b1, b);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 8'($urandom));
    endtask

    task automatic clearObs();
        obs_wr  = 0;
        obs_err = 0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n     = 1'b0;
        bus.rx_dv = 1'b0;
        #1;
        modelReset();
        checkAll();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] bw;
        logic [7:0]  a, d, c;
        int          exp_errs;
        int          big_gaps;
        int          len;

`ifdef UART_CMD_CHKSUM_EN
        vecs[0] = '{3'd4, 32'hA5035C5F, 16'd1000, 1'b1, 4'h3, 8'h5C, 1'b0};
        vecs[1] = '{3'd4, 32'hA5035C00, 16'd5,    1'b0, 4'h0, 8'h00, 1'b1};
        vecs[2] = '{3'd2, 32'hA5120000, 16'd3,    1'b0, 4'h0, 8'h00, 1'b1};
        vecs[3] = '{3'd4, 32'hA5027775, 16'd2,    1'b1, 4'h2, 8'h77, 1'b0};
        vecs[4] = '{3'd4, 32'hA505A5A0, 16'd4,    1'b1, 4'h5, 8'hA5, 1'b0};
`else
        vecs[0] = '{3'd3, 32'hA5035C00, 16'd1000, 1'b1, 4'h3, 8'h5C, 1'b0};
        vecs[1] = '{3'd2, 32'hA5130000, 16'd5,    1'b0, 4'h0, 8'h00, 1'b1};
        vecs[2] = '{3'd3, 32'hA5027700, 16'd2,    1'b1, 4'h2, 8'h77, 1'b0};
        vecs[3] = '{3'd3, 32'hA50FFF00, 16'd3,    1'b1, 4'hF, 8'hFF, 1'b0};
        vecs[4] = '{3'd3, 32'hA505A500, 16'd4,    1'b1, 4'h5, 8'hA5, 1'b0};
`endif

        bus.rx_dv   = 1'b0;
        bus.rx_byte = 8'd0;
        modelReset();
        clearObs();
        repeat (3) @(negedge clk);
        checkAll();
        rst_n = 1'b1;

        // Table-driven frames
        exp_errs = 0;
        for (int i = 0; i < 5; i++) begin
            clearObs();
            bw = vecs[i].bytes;
            for (int k = 0; k < int'(vecs[i].n); k++)
                applyStimulus(bw[31-8*k -: 8], (k == 0) ? 2 : int'(vecs[i].gap));
            idle(4);
            checkOutput($sformatf("vec%0d wr count", i), obs_wr, 32'(vecs[i].exp_wr));
            checkOutput($sformatf("vec%0d err count", i), obs_err, 32'(vecs[i].exp_err));
            if (vecs[i].exp_wr) begin
                checkOutput($sformatf("vec%0d addr", i), 32'(obs_addr), 32'(vecs[i].exp_addr));
                checkOutput($sformatf("vec%0d data", i), 32'(obs_data), 32'(vecs[i].exp_data));
            end
            exp_errs += int'(vecs[i].exp_err);
        end
        checkOutput("err_cnt after table", 32'(bus.err_cnt), 32'(exp_errs));

        // Timeout: SYNC then silence
        doReset();
        clearObs();
        applyStimulus(SYNC, 2);
        idle(TMO + 3);
        checkOutput("timeout err count", obs_err, 1);
        checkOutput("timeout busy", 32'(bus.busy), 0);
        checkOutput("timeout err_cnt", 32'(bus.err_cnt), 1);

        // DATA byte on the exact expiry cycle is accepted
        clearObs();
        applyStimulus(SYNC, 2);
        applyStimulus(8'h01, 2);
        applyStimulus(8'h3C, TMO + 1);
`ifdef UART_CMD_CHKSUM_EN
        applyStimulus(8'h3D, 2);
`endif
        idle(4);
        checkOutput("expiry err count", obs_err, 0);
        checkOutput("expiry wr count", obs_wr, 1);
        checkOutput("expiry data", 32'(obs_data), 32'h3C);

        // One clock later is too late
        clearObs();
        applyStimulus(SYNC, 2);
        applyStimulus(8'h01, TMO + 2);
        idle(4);
        checkOutput("late err count", obs_err, 1);
        checkOutput("late wr count", obs_wr, 0);

        // Noise in IDLE
        clearObs();
        applyStimulus(8'h00, 3);
        applyStimulus(8'hFF, 3);
        applyStimulus(8'h5A, 3);
        idle(3);
        checkOutput("noise err count", obs_err, 0);
        checkOutput("noise busy", 32'(bus.busy), 0);

        // Error counter saturation
        clearObs();
        repeat (257) begin
            applyStimulus(SYNC, 1);
            applyStimulus(8'h10, 1);
        end
        idle(3);
        checkOutput("sat err pulses", obs_err, 257);
        checkOutput("sat err_cnt", 32'(bus.err_cnt), 32'hFF);

        // Reset in the middle of a frame
        clearObs();
        applyStimulus(SYNC, 2);
        applyStimulus(8'h04, 2);
        doReset();
        idle(3);
        checkOutput("midrst err count", obs_err, 0);
        checkOutput("midrst wr count", obs_wr, 0);
        applyStimulus(SYNC, 2);
        applyStimulus(8'h06, 2);
        applyStimulus(8'h11, 2);
`ifdef UART_CMD_CHKSUM_EN
        applyStimulus(8'h17, 2);
`endif
        idle(4);
        checkOutput("post-rst wr count", obs_wr, 1);
        checkOutput("post-rst addr", 32'(obs_addr), 32'h6);
        checkOutput("post-rst data", 32'(obs_data), 32'h11);

        // Randomized frame stream, checked every cycle against the model
        big_gaps = 0;
        for (int f = 0; f < 150; f++) begin
            a   = 8'($urandom_range(0, 19));
            d   = 8'($urandom);
            c   = ($urandom_range(0, 3) != 0) ? (a ^ d) : 8'($urandom);
            len = ($urandom_range(0, 5) == 0) ? $urandom_range(1, NB) : NB;
            if ($urandom_range(0, 4) == 0) applyStimulus(8'($urandom), $urandom_range(1, 4));
            for (int k = 0; k < len; k++) begin
                int g;
                g = $urandom_range(1, 6);
                if (big_gaps < 6 && $urandom_range(0, 59) == 0) begin
                    g = TMO + $urandom_range(1, 2);
                    big_gaps++;
                end
                case (k)
                    0:       applyStimulus(SYNC, g);
                    1:       applyStimulus(a, g);
                    2:       applyStimulus(d, g);
                    default: applyStimulus(c, g);
                endcase
            end
        end
        idle(TMO + 5);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
